bsram_sample_capture: RTL and testbench
=======================================

Name: bsram_sample_capture

Overview:
- Upstream write/readout controller for the 512x36 acquisition sample BSRAM.
- Accepts a stream of 4-bit complex front-end samples (2-bit I, 2-bit Q) and packs 9 samples per 36-bit word.
- Writes a block of NUM_WORDS words sequentially from address 0, then holds the buffer for the correlator's random-access reads, which it arbitrates onto the same single RAM port.

Parameters:
- NUM_WORDS, 512, words captured per block (1..512).
- ADDR_LSB, 5, left shift applied to the word address to form AD (RAM uses AD[13:5]).

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin a new capture
- sample_valid  in  1  sample strobe
- sample_i  in  2  in-phase sample
- sample_q  in  2  quadrature sample
- busy  out  1  capture in progress
- done  out  1  buffer full and readable (level)
- rd_req  in  1  read request (one cycle)
- rd_addr  in  9  word address to read
- rd_valid  out  1  rd_data valid this cycle
- rd_data  out  36  read word
- AD  out  14  RAM address
- DI  out  36  RAM write data
- WRE  out  1  RAM write enable
- CE  out  1  RAM clock enable
- DO  in  36  RAM read data

Behaviour:
- Reset (RESET low, asynchronous): state IDLE; AD, DI, WRE, CE, busy, done, and rd_valid all 0; pack count, word address and shift register cleared. A partial word or capture in progress is discarded.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE: start goes to CAPTURE.
  - CAPTURE: the write of word NUM_WORDS-1 goes to DONE.
  - DONE: start goes to CAPTURE (restart, done drops the next cycle).
- busy = (state==CAPTURE); done = (state==DONE). Both are registered.
- Packing:
  - Sample k (k=0..8) of a word occupies DI[4k+3:4k], with sample_i in [4k+3:4k+2] and sample_q in [4k+1:4k].
  - Only sample_valid cycles advance the pack count (0..8).
  - sample_valid is ignored in IDLE and DONE.
  - A sample_valid in the same cycle as the start that enters CAPTURE is ignored.
- Write issue:
  - The cycle after the 9th sample is accepted, WRE=1, CE=1, DI=packed word, AD={wr_addr,5'b0} for exactly one cycle. wr_addr then increments.
  - Samples continue to be accepted back-to-back during that cycle; there is no stall.
- End of block:
  - After word NUM_WORDS-1 is issued, the state is DONE.
  - Any further samples are dropped.
  - wr_addr never wraps within a block; it resets to 0 on each start.
- Read path:
  - Reads are serviced only in IDLE or DONE. rd_req in CAPTURE is ignored and rd_valid stays 0.
  - rd_req at cycle t gives WRE=0, CE=1, AD={rd_addr,5'b0} registered in t+1. The RAM registers DO at the end of t+1. rd_valid=1 in t+2.
  - rd_data = DO (combinational pass-through). Read latency is 2 cycles.
  - Back-to-back rd_req every cycle is allowed, giving one rd_valid per cycle.
- Port arbitration: when no write or read is issued, WRE=0 and CE=0, and AD and DI hold their last values.
- Simultaneous events:
  - start and rd_req in the same cycle: start wins and the read is dropped.
  - start during CAPTURE is ignored.
  - A read in flight when start arrives still completes (rd_valid at t+2).

Test Plan:
- Reset then start, with 9 samples of I=2'b01, Q=2'b10 (nibble 4'h6) on consecutive cycles -> one cycle after the 9th sample, WRE=1, AD=14'h0000, DI=36'h666666666. busy=1 throughout capture.
- NUM_WORDS=4, 36 samples with ramp nibble value (k mod 16) -> 4 writes at AD=0x000,0x020,0x040,0x060. Word 0 DI=36'h876543210. done=1 after the 4th write. The 37th sample produces no WRE.
- After done, rd_req with rd_addr=2 at cycle t -> AD=0x040 with WRE=0 at t+1, rd_valid=1 at t+2, rd_data equals the word-2 value. Also check 3 consecutive reads give 3 consecutive rd_valid cycles.
- rd_req during CAPTURE -> no AD change, rd_valid stays 0. sample_valid in IDLE -> no write, pack count unchanged.
- Drop RESET low after 5 samples of word 3 -> all outputs 0 immediately (asynchronous). A new start plus 9 samples writes at AD=0x000.
- Start in DONE, with simultaneous rd_req -> capture restarts at address 0, done=0 the next cycle, and no rd_valid is produced for that request.

Source files
------------

// File: rtl/bsram_sample_capture.sv
// bsram_sample_capture
// Write/readout controller for the 512x36 acquisition sample BSRAM.
// Packs nine 4-bit complex samples (2-bit I, 2-bit Q) per 36-bit word, writes a
// block of NUM_WORDS words from address 0, then serves correlator reads on the
// same single RAM port.
module bsram_sample_capture #(
    parameter int unsigned NUM_WORDS = 512,
    parameter int unsigned ADDR_LSB  = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic        sample_valid,
    input  logic [1:0]  sample_i,
    input  logic [1:0]  sample_q,
    output logic        busy,
    output logic        done,
    input  logic        rd_req,
    input  logic [8:0]  rd_addr,
    output logic        rd_valid,
    output logic [35:0] rd_data,
    output logic [13:0] AD,
    output logic [35:0] DI,
    output logic        WRE,
    output logic        CE,
    input  logic [35:0] DO
);

    localparam int unsigned AW  = 9;   // word address width
    localparam int unsigned DW  = 36;  // RAM word width
    localparam int unsigned ADW = 14;  // RAM AD port width
    localparam int unsigned SPW = 4;   // bits per complex sample
    localparam int unsigned SPP = 9;   // samples per word
    localparam int unsigned CW  = 4;   // pack counter width
    localparam int unsigned SHW = DW - SPW;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(SPP - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Word address to RAM AD: zero-extend, then shift into the RAM's address field.
    function automatic logic [ADW-1:0] word_to_ad(input logic [AW-1:0] a);
        logic [ADW-1:0] ext;
        ext = {{(ADW - AW){1'b0}}, a};
        return ADW'(ext << ADDR_LSB);
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW-1:0]   r_pack_cnt;
    logic [SHW-1:0]  r_shift;
    logic [AW-1:0]   r_wr_addr;

    logic [ADW-1:0]  r_ad;
    logic [DW-1:0]   r_di;
    logic            r_wre;
    logic            r_ce;
    logic            r_busy;
    logic            r_done;
    logic            r_rd_pend;
    logic            r_rd_valid;

    logic [ADW-1:0]  w_ad_nxt;
    logic [DW-1:0]   w_di_nxt;
    logic            w_wre_nxt;
    logic            w_ce_nxt;

    logic            w_capturing;
    logic            w_start_cap;
    logic            w_accept;
    logic            w_word_full;
    logic            w_last_word;
    logic            w_rd_issue;
    logic [SPW-1:0]  w_nibble;
    logic [DW-1:0]   w_word;

    // Qualify incoming events against the current state.
    always_comb begin
        w_capturing = (r_state == CAPTURE);
        // start while capturing is ignored; otherwise it (re)starts the block
        w_start_cap = start && !w_capturing;
        // samples only count while capturing, never in the cycle that enters CAPTURE
        w_accept    = sample_valid && w_capturing;
        w_word_full = w_accept && (r_pack_cnt == LAST_SLOT);
        w_last_word = w_word_full && (r_wr_addr == LAST_ADDR);
        // reads only outside capture, and a simultaneous start drops them
        w_rd_issue  = rd_req && !w_capturing && !start;
        w_nibble    = {sample_i, sample_q};
        // newest sample lands in the top nibble, so sample 0 ends up in DI[3:0]
        w_word      = {w_nibble, r_shift};
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_last_word) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = CAPTURE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // RAM port arbitration: a completed word write or a read; otherwise idle, AD/DI held.
    always_comb begin
        w_wre_nxt = 1'b0;
        w_ce_nxt  = 1'b0;
        w_ad_nxt  = r_ad;
        w_di_nxt  = r_di;
        if (w_word_full) begin
            w_wre_nxt = 1'b1;
            w_ce_nxt  = 1'b1;
            w_ad_nxt  = word_to_ad(r_wr_addr);
            w_di_nxt  = w_word;
        end else if (w_rd_issue) begin
            w_ce_nxt  = 1'b1;
            w_ad_nxt  = word_to_ad(rd_addr);
        end
    end

    // Sample packing and write address; a start clears any partial word.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pack_cnt <= '0;
            r_shift    <= '0;
            r_wr_addr  <= '0;
        end else if (w_start_cap) begin
            r_pack_cnt <= '0;
            r_shift    <= '0;
            r_wr_addr  <= '0;
        end else if (w_accept) begin
            r_shift <= w_word[DW-1:SPW];
            if (w_word_full) begin
                r_pack_cnt <= '0;
                // hold on the last word so the address never wraps inside a block
                if (!w_last_word) begin
                    r_wr_addr <= r_wr_addr + AW'(1);
                end
            end else begin
                r_pack_cnt <= r_pack_cnt + CW'(1);
            end
        end
    end

    // Registered RAM port and status outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ad   <= '0;
            r_di   <= '0;
            r_wre  <= 1'b0;
            r_ce   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_ad   <= w_ad_nxt;
            r_di   <= w_di_nxt;
            r_wre  <= w_wre_nxt;
            r_ce   <= w_ce_nxt;
            r_busy <= (w_state_nxt == CAPTURE);
            r_done <= (w_state_nxt == DONE);
        end
    end

    // Read valid pipeline: address cycle, then RAM output register cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_pend  <= w_rd_issue;
            r_rd_valid <= r_rd_pend;
        end
    end

    assign AD       = r_ad;
    assign DI       = r_di;
    assign WRE      = r_wre;
    assign CE       = r_ce;
    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_valid = r_rd_valid;
    // RAM output is already registered inside the BSRAM
    assign rd_data  = DO;

endmodule

// File: tb/tb_bsram_sample_capture.sv
// Bench for bsram_sample_capture with a behavioural 512x36 RAM on the port.
// Expected writes and reads are queued when stimulus is driven and checked by a
// monitor when WRE / rd_valid appear; tasks check timing-specific values inline.
module tb_bsram_sample_capture;

    localparam int unsigned NW = 4;

    typedef struct {
        logic [13:0] ad;
        logic [35:0] di;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [35:0] d;
        int          cyc;
    } rd_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [1:0]  sample_i = 2'b00;
    logic [1:0]  sample_q = 2'b00;
    logic        busy;
    logic        done;
    logic        rd_req = 1'b0;
    logic [8:0]  rd_addr = 9'd0;
    logic        rd_valid;
    logic [35:0] rd_data;
    logic [13:0] AD;
    logic [35:0] DI;
    logic        WRE;
    logic        CE;
    logic [35:0] DO;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    wr_t wq[$];
    rd_t rq[$];

    logic [35:0] exp_mem [0:511];
    logic [35:0] ram     [0:511];

    // bench model of the capture state
    bit          m_cap = 1'b0;
    int          m_cnt = 0;
    int          m_addr = 0;
    logic [35:0] m_word = '0;

    bsram_sample_capture #(
        .NUM_WORDS (NW),
        .ADDR_LSB  (5)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .start        (start),
        .sample_valid (sample_valid),
        .sample_i     (sample_i),
        .sample_q     (sample_q),
        .busy         (busy),
        .done         (done),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .AD           (AD),
        .DI           (DI),
        .WRE          (WRE),
        .CE           (CE),
        .DO           (DO)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // single-port BSRAM with registered output
    always @(posedge CLK) begin
        if (CE === 1'b1) begin
            if (WRE === 1'b1) ram[AD[13:5]] <= DI;
            else              DO <= ram[AD[13:5]];
        end
    end

    // scoreboard consumer
    always @(negedge CLK) begin : monitor
        wr_t w;
        rd_t r;
        if (RESET === 1'b1) begin
            if (WRE === 1'b1) begin
                n_cmp++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: cyc=%0d AD=%h DI=%h, required no write", cyc, AD, DI);
                end else begin
                    w = wq.pop_front();
                    if (AD !== w.ad || DI !== w.di || CE !== 1'b1 || cyc !== w.cyc) begin
                        n_fail++;
                        $display("FAIL write: got AD=%h DI=%h CE=%b cyc=%0d, required AD=%h DI=%h CE=1 cyc=%0d",
                                 AD, DI, CE, cyc, w.ad, w.di, w.cyc);
                    end
                end
            end
            if (rd_valid === 1'b1) begin
                n_cmp++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rd_valid: cyc=%0d rd_data=%h, required no rd_valid", cyc, rd_data);
                end else begin
                    r = rq.pop_front();
                    if (rd_data !== r.d || cyc !== r.cyc) begin
                        n_fail++;
                        $display("FAIL read: got rd_data=%h cyc=%0d, required rd_data=%h cyc=%0d",
                                 rd_data, cyc, r.d, r.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // drive one valid sample for a cycle and update the packing model
    task automatic send_sample(input logic [3:0] nib);
        wr_t w;
        sample_valid = 1'b1;
        sample_i     = nib[3:2];
        sample_q     = nib[1:0];
        if (m_cap) begin
            m_word[4*m_cnt +: 4] = nib;
            m_cnt++;
            if (m_cnt == 9) begin
                w.ad  = 14'(m_addr << 5);
                w.di  = m_word;
                w.cyc = cyc + 1;
                wq.push_back(w);
                exp_mem[m_addr] = m_word;
                m_addr++;
                m_cnt = 0;
                if (m_addr == NW) m_cap = 1'b0;
            end
        end
        step();
        sample_valid = 1'b0;
    endtask

    task automatic model_start();
        if (!m_cap) begin
            m_cap  = 1'b1;
            m_cnt  = 0;
            m_addr = 0;
        end
    endtask

    task automatic push_read(input int a, input int lat);
        rd_t r;
        r.d   = exp_mem[a];
        r.cyc = cyc + lat;
        rq.push_back(r);
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        step();
        step();
        n_cmp++;
        if ({busy, done, WRE, CE, rd_valid, AD, DI} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b WRE=%b CE=%b rd_valid=%b AD=%h DI=%h, required all 0",
                     busy, done, WRE, CE, rd_valid, AD, DI);
        end
        RESET = 1'b1;
        step();
    endtask

    task automatic test_idle_samples();
        for (int i = 0; i < 9; i++) begin
            send_sample(4'h9);
            n_cmp++;
            if (WRE !== 1'b0 || CE !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_sample: WRE=%b CE=%b busy=%b, required 0 0 0", WRE, CE, busy);
            end
        end
    endtask

    task automatic test_single_word();
        // sample in the start cycle must be ignored
        start        = 1'b1;
        sample_valid = 1'b1;
        sample_i     = 2'b11;
        sample_q     = 2'b11;
        model_start();
        step();
        start        = 1'b0;
        sample_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy: busy=%b done=%b, required 1 0", busy, done);
        end
        for (int i = 0; i < 9; i++) begin
            send_sample(4'h6);
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_capture: busy=%b, required 1", busy);
            end
        end
        n_cmp++;
        if (WRE !== 1'b1 || CE !== 1'b1 || AD !== 14'h0000 || DI !== 36'h666666666) begin
            n_fail++;
            $display("FAIL first_word: WRE=%b CE=%b AD=%h DI=%h, required 1 1 0000 666666666", WRE, CE, AD, DI);
        end
    endtask

    task automatic test_read_in_capture();
        logic [13:0] prev_ad;
        // start during capture is ignored (next write still at word 1)
        start = 1'b1;
        step();
        start = 1'b0;
        prev_ad = AD;
        rd_req  = 1'b1;
        rd_addr = 9'd3;
        step();
        rd_req  = 1'b0;
        n_cmp++;
        if (AD !== prev_ad || CE !== 1'b0 || WRE !== 1'b0) begin
            n_fail++;
            $display("FAIL read_in_capture: AD=%h CE=%b WRE=%b, required AD=%h CE=0 WRE=0", AD, CE, WRE, prev_ad);
        end
        step();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_in_capture_valid: rd_valid=%b, required 0", rd_valid);
        end
        for (int i = 0; i < 27; i++) send_sample(4'h6);
        step();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_after_block: done=%b busy=%b, required 1 0", done, busy);
        end
    endtask

    task automatic test_ramp();
        start = 1'b1;
        model_start();
        step();
        start = 1'b0;
        for (int k = 0; k < 37; k++) begin
            send_sample(4'(k % 16));
            if (k == 8) begin
                n_cmp++;
                if (WRE !== 1'b1 || AD !== 14'h0000 || DI !== 36'h876543210) begin
                    n_fail++;
                    $display("FAIL ramp_word0: WRE=%b AD=%h DI=%h, required 1 0000 876543210", WRE, AD, DI);
                end
            end
        end
        n_cmp++;
        if (WRE !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL extra_sample: WRE=%b done=%b, required 0 1", WRE, done);
        end
        step();
        n_cmp++;
        if (WRE !== 1'b0 || wq.size() != 0) begin
            n_fail++;
            $display("FAIL ramp_drain: WRE=%b pending=%0d, required 0 0", WRE, wq.size());
        end
    endtask

    task automatic test_read();
        logic [5:0] v;
        rd_req  = 1'b1;
        rd_addr = 9'd2;
        push_read(2, 2);
        step();
        rd_req = 1'b0;
        n_cmp++;
        if (AD !== 14'h0040 || WRE !== 1'b0 || CE !== 1'b1) begin
            n_fail++;
            $display("FAIL read_addr: AD=%h WRE=%b CE=%b, required 0040 0 1", AD, WRE, CE);
        end
        step();
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 36'hA98765432) begin
            n_fail++;
            $display("FAIL read_word2: rd_valid=%b rd_data=%h, required 1 a98765432", rd_valid, rd_data);
        end
        v = '0;
        for (int j = 0; j < 6; j++) begin
            if (j < 3) begin
                rd_req  = 1'b1;
                rd_addr = 9'(j);
                push_read(j, 2);
            end else begin
                rd_req = 1'b0;
            end
            step();
            v[j] = rd_valid;
        end
        rd_req = 1'b0;
        n_cmp++;
        if (v !== 6'b001110) begin
            n_fail++;
            $display("FAIL back_to_back_reads: rd_valid pattern=%b, required 001110", v);
        end
    endtask

    task automatic test_restart_with_read();
        rd_req  = 1'b1;
        rd_addr = 9'd1;
        push_read(1, 2);
        step();
        // start wins over this request; the previous read still completes
        start   = 1'b1;
        rd_req  = 1'b1;
        rd_addr = 9'd3;
        model_start();
        step();
        start  = 1'b0;
        rd_req = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1 || CE !== 1'b0) begin
            n_fail++;
            $display("FAIL restart: done=%b busy=%b CE=%b, required 0 1 0", done, busy, CE);
        end
        n_cmp++;
        if (rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_read: rd_valid=%b, required 1", rd_valid);
        end
        step();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dropped_read: rd_valid=%b, required 0", rd_valid);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 32; i++) send_sample(4'($urandom_range(15, 0)));
        #2;
        RESET = 1'b0;
        m_cap = 1'b0;
        m_cnt = 0;
        #1;
        n_cmp++;
        if ({busy, done, WRE, CE, rd_valid, AD, DI} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b WRE=%b CE=%b rd_valid=%b AD=%h DI=%h, required all 0",
                     busy, done, WRE, CE, rd_valid, AD, DI);
        end
        step();
        step();
        RESET = 1'b1;
        step();
        start = 1'b1;
        model_start();
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) send_sample(4'($urandom_range(15, 0)));
        n_cmp++;
        if (WRE !== 1'b1 || AD !== 14'h0000) begin
            n_fail++;
            $display("FAIL post_reset_write: WRE=%b AD=%h, required 1 0000", WRE, AD);
        end
        step();
        step();
        n_cmp++;
        if (wq.size() != 0 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL queues_drained: writes pending=%0d reads pending=%0d, required 0 0", wq.size(), rq.size());
        end
    endtask

    initial begin
        test_reset();
        test_idle_samples();
        test_single_word();
        test_read_in_capture();
        test_ramp();
        test_read();
        test_restart_with_read();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
